tc_wl_fetch: RTL
================

// Module: tc_wl_fetch
// PURPOSE
//  Work-list fetch stage directly upstream of the task-controller work-item queue.
//  - Given a line-aligned base address and a work-item count, fetches 512-bit lines
//    over a valid/ready memory request port.
//  - Unpacks each line into WI_WIDTH-bit work items and pushes them, in order, into
//    the work-item FIFO, honouring its full flag.
// PARAMETERS
//  ADDR_WIDTH   64   byte address width
//  DATA_WIDTH   512  memory line width (bits); LINE_BYTES = DATA_WIDTH/8
//  WL_LEN_BITS  32   width of the work-item count
//  WI_WIDTH     64   work-item width; WI_PER_LINE = DATA_WIDTH/WI_WIDTH (8 by default)
// PORTS
//  clk              in   1            clock
//  reset            in   1            asynchronous reset, active-high
//  start_i          in   1            1-cycle start pulse; sampled only in IDLE
//  wl_base_i        in   ADDR_WIDTH   work-list base; low log2(LINE_BYTES) bits must be 0
//  wl_len_i         in   WL_LEN_BITS  number of work items to fetch
//  abort_i          in   1            cancel the current fetch
//  busy_o           out  1            fetch in progress
//  done_o           out  1            1-cycle pulse at end of fetch (normal, error or abort)
//  err_o            out  1            sticky error flag; cleared by the next accepted start
//  mem_req_valid_o  out  1            line request valid
//  mem_req_ready_i  in   1            line request accepted
//  mem_req_addr_o   out  ADDR_WIDTH   line address
//  mem_rsp_valid_i  in   1            line response valid (always accepted)
//  mem_rsp_data_i   in   DATA_WIDTH   line data
//  mem_rsp_err_i    in   1            response error
//  wi_push_o        out  1            FIFO push
//  wi_data_o        out  WI_WIDTH     work item
//  wi_full_i        in   1            FIFO full
//  stat_lines_o     out  32           lines fetched (feature-gated)
//  stat_stall_o     out  32           cycles blocked by wi_full_i (feature-gated)
// BEHAVIOUR
//  - Reset: state IDLE; every output 0; internal counters and line buffer cleared.
//    Reset asserted mid-operation abandons the fetch immediately; no done_o pulse.
//  - FSM states: IDLE, REQ, WAIT, UNPACK, DRAIN, FIN.
//  - IDLE + start_i:
//    - misaligned base -> FIN with err_o=1; no request issued.
//    - wl_len_i==0 -> FIN; no request issued.
//    - otherwise latch base and length, clear err_o, -> REQ.
//    - start_i outside IDLE is ignored.
//  - REQ: mem_req_valid_o=1, addr = base + line_idx*LINE_BYTES (mod 2^ADDR_WIDTH).
//    Valid and addr stay stable until mem_req_ready_i; the ready cycle -> WAIT.
//    One request outstanding at most.
//  - WAIT: on mem_rsp_valid_i capture the line.
//    - mem_rsp_err_i -> FIN with err_o=1; nothing pushed from that line.
//    - otherwise -> UNPACK.
//  - UNPACK: item k = line[k*WI_WIDTH +: WI_WIDTH], k from 0.
//    - wi_push_o = !wi_full_i; one item per cycle; wi_data_o held stable while full.
//    - Items pushed this line = min(WI_PER_LINE, remaining); unused tail items are dropped.
//    - After the last item of the line: remaining>0 -> REQ, else -> FIN.
//  - FIN: done_o=1 for one cycle, busy_o=0 from this cycle, -> IDLE.
//    busy_o=1 in REQ, WAIT, UNPACK and DRAIN.
//  - abort_i:
//    - in REQ before the handshake -> FIN; the request is withdrawn.
//    - in WAIT -> DRAIN; discard the pending response, then FIN.
//    - in UNPACK -> FIN; no further pushes.
//    - abort_i in the same cycle as mem_req_ready_i: the request counts as issued -> DRAIN.
//  - Latency: start to first mem_req_valid_o is 1 cycle; response to first push is
//    1 cycle; last push to done_o is 1 cycle.
// CONFIGURATION
//  TC_WL_FETCH_STATS_EN defined:
//  - stat_lines_o counts accepted non-error responses.
//  - stat_stall_o counts UNPACK cycles with wi_full_i=1.
//  - Both saturate at 2^32-1, clear on reset only, and are not cleared by start.
//  Undefined: both ports are tied to 0 and no counter flops are built.
// STRUCTURE
//  tc_pkg: tc_wl_state_e enum, LINE_BYTES, WI_PER_LINE, LINE_OFS_BITS constants.
//  Sub-module tc_line_unpacker: line register, item index, item select, last-item flag.
// TESTING
//  1. base=0x1000, len=8, never full -> one request at 0x1000; 8 pushes of items 0..7
//     on consecutive cycles; done_o pulse 1 cycle after the 8th push.
//  2. len=11 -> requests at 0x1000 then 0x1040; 8+3 pushes; items 3..7 of line 2
//     never pushed.
//  3. len=0, then base=0x1008 len=4 -> each gives done_o 1 cycle after start with no
//     request; err_o=0 for the first, err_o=1 for the second.
//  4. wi_full_i high 5 cycles at item 2 -> no push for those 5 cycles, wi_data_o stable,
//     item 2 pushed first cycle full drops; stat_stall_o=5 (macro defined).
//  5. len=16, mem_rsp_err_i on line 2 -> 8 pushes only, err_o=1, done_o pulse;
//     next start clears err_o.
//  6. abort_i in WAIT -> late response discarded, zero pushes, single done_o;
//     reset mid-UNPACK -> all outputs 0 the same cycle.

Source files
------------

// File: rtl/tc_pkg.sv
// Shared types and default geometry for the task-controller work-list fetch stage.
// The default line layout is 512-bit lines carrying eight 64-bit work items.
package tc_pkg;

    localparam int TC_ADDR_WIDTH  = 64;
    localparam int TC_DATA_WIDTH  = 512;
    localparam int TC_WL_LEN_BITS = 32;
    localparam int TC_WI_WIDTH    = 64;

    localparam int LINE_BYTES    = TC_DATA_WIDTH / 8;
    localparam int WI_PER_LINE   = TC_DATA_WIDTH / TC_WI_WIDTH;
    localparam int LINE_OFS_BITS = $clog2(LINE_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_UNPACK,
        ST_DRAIN,
        ST_FIN
    } tc_wl_state_e;

    // Width of an index over n items, never narrower than one bit.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tc_line_unpacker.sv
// Holds one fetched memory line and walks through its work items in order.
// item_o is the item at the current index; last_o flags the final slot of the line.
module tc_line_unpacker
    import tc_pkg::*;
#(
    parameter int DATA_WIDTH = TC_DATA_WIDTH,
    parameter int WI_WIDTH   = TC_WI_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] line_i,
    input  logic                  adv_i,
    output logic [WI_WIDTH-1:0]   item_o,
    output logic                  last_o
);

    localparam int N_ITEMS = DATA_WIDTH / WI_WIDTH;
    localparam int IDX_W   = idx_bits(N_ITEMS);

    logic [N_ITEMS-1:0][WI_WIDTH-1:0] line_q;
    logic [IDX_W-1:0]                 idx_q;

    // Capture a new line and restart at item 0, or step to the next item.
    // NOTE: state is written with <= so every flop samples the pre-edge value of its inputs.
    // NOTE: the line buffer is cleared on reset (unlike a RAM) so wi_data_o reads 0 out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_q <= '0;
            idx_q  <= '0;
        end else if (load_i) begin
            line_q <= line_i;
            idx_q  <= '0;
        end else if (adv_i) begin
            idx_q  <= idx_q + 1'b1;
        end
    end

    assign item_o = line_q[idx_q];
    assign last_o = (idx_q == IDX_W'(N_ITEMS - 1));

endmodule

// File: rtl/tc_wl_fetch.sv
// Work-list fetch stage: reads line-aligned work-list lines over a valid/ready
// request port and pushes their work items, in order, into the work-item FIFO.
// Optional statistics counters are built when TC_WL_FETCH_STATS_EN is defined.
module tc_wl_fetch
    import tc_pkg::*;
#(
    parameter int ADDR_WIDTH  = TC_ADDR_WIDTH,
    parameter int DATA_WIDTH  = TC_DATA_WIDTH,
    parameter int WL_LEN_BITS = TC_WL_LEN_BITS,
    parameter int WI_WIDTH    = TC_WI_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_i,
    input  logic [ADDR_WIDTH-1:0]  wl_base_i,
    input  logic [WL_LEN_BITS-1:0] wl_len_i,
    input  logic                   abort_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic                   mem_req_valid_o,
    input  logic                   mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0]  mem_req_addr_o,
    input  logic                   mem_rsp_valid_i,
    input  logic [DATA_WIDTH-1:0]  mem_rsp_data_i,
    input  logic                   mem_rsp_err_i,
    output logic                   wi_push_o,
    output logic [WI_WIDTH-1:0]    wi_data_o,
    input  logic                   wi_full_i,
    output logic [31:0]            stat_lines_o,
    output logic [31:0]            stat_stall_o
);

    localparam int STEP_BYTES = DATA_WIDTH / 8;
    localparam int OFS_BITS   = $clog2(STEP_BYTES);

    tc_wl_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [WL_LEN_BITS-1:0] rem_q;
    logic                   err_q;
    logic                   line_load;
    logic                   push;
    logic                   last_item;
    logic                   misaligned;
    logic                   rem_one;

    assign misaligned = (wl_base_i[OFS_BITS-1:0] != '0);
    assign rem_one    = (rem_q == WL_LEN_BITS'(1));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state and handshake decode.
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        line_load = 1'b0;
        push      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (misaligned || wl_len_i == '0) state_d = ST_FIN;
                    else                              state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // A request accepted in the abort cycle is in flight: drain its response.
                if (mem_req_ready_i) state_d = abort_i ? ST_DRAIN : ST_WAIT;
                else if (abort_i)    state_d = ST_FIN;
            end
            ST_WAIT: begin
                if (abort_i) begin
                    // A response arriving with the abort is simply the one being discarded.
                    state_d = mem_rsp_valid_i ? ST_FIN : ST_DRAIN;
                end else if (mem_rsp_valid_i) begin
                    if (mem_rsp_err_i) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d   = ST_UNPACK;
                        line_load = 1'b1;
                    end
                end
            end
            ST_UNPACK: begin
                if (abort_i) begin
                    state_d = ST_FIN;
                end else if (!wi_full_i) begin
                    push = 1'b1;
                    if (rem_one)        state_d = ST_FIN;
                    else if (last_item) state_d = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (mem_rsp_valid_i) state_d = ST_FIN;
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Work-list cursor (line address, items remaining) and sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
            rem_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && start_i) begin
                if (misaligned) begin
                    err_q <= 1'b1;
                end else if (wl_len_i != '0) begin
                    addr_q <= wl_base_i;
                    rem_q  <= wl_len_i;
                    err_q  <= 1'b0;
                end
            end
            if (state_q == ST_WAIT && mem_rsp_valid_i && mem_rsp_err_i && !abort_i) begin
                err_q <= 1'b1;
            end
            if (push) begin
                rem_q <= rem_q - WL_LEN_BITS'(1);
                if (last_item && !rem_one) addr_q <= addr_q + ADDR_WIDTH'(STEP_BYTES);
            end
        end
    end

    tc_line_unpacker #(
        .DATA_WIDTH (DATA_WIDTH),
        .WI_WIDTH   (WI_WIDTH)
    ) u_unpacker (
        .clk    (clk),
        .reset  (reset),
        .load_i (line_load),
        .line_i (mem_rsp_data_i),
        .adv_i  (push),
        .item_o (wi_data_o),
        .last_o (last_item)
    );

    assign busy_o          = (state_q == ST_REQ) || (state_q == ST_WAIT) ||
                             (state_q == ST_UNPACK) || (state_q == ST_DRAIN);
    assign done_o          = (state_q == ST_FIN);
    assign err_o           = err_q;
    assign mem_req_valid_o = (state_q == ST_REQ);
    assign mem_req_addr_o  = addr_q;
    assign wi_push_o       = push;

`ifdef TC_WL_FETCH_STATS_EN
    logic [31:0] lines_q;
    logic [31:0] stall_q;

    // Saturating counts of good lines received and FIFO-full stall cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lines_q <= '0;
            stall_q <= '0;
        end else begin
            if (line_load && lines_q != '1) lines_q <= lines_q + 32'd1;
            if (state_q == ST_UNPACK && wi_full_i && stall_q != '1) stall_q <= stall_q + 32'd1;
        end
    end

    assign stat_lines_o = lines_q;
    assign stat_stall_o = stall_q;
`else
    assign stat_lines_o = '0;
    assign stat_stall_o = '0;
`endif

endmodule
